// File: rtl/virtual_slave_regbank_pkg.sv
// Shared constants and types for the virtual slave register bank.
// Register indices, field positions, timer state encoding and the unmapped-read pattern.
package virtual_slave_regbank_pkg;
   localparam int unsigned C_IDX_CTRL   = 0;
   localparam int unsigned C_IDX_COUNT  = 1;
   localparam int unsigned C_IDX_STATUS = 2;
   localparam int unsigned C_IDX_REMAIN = 3;
   localparam int unsigned C_IDX_SCR0   = 4;

   localparam int unsigned C_CTRL_START  = 0;
   localparam int unsigned C_CTRL_IRQ_EN = 1;
   localparam int unsigned C_CTRL_ABORT  = 2;

   localparam int unsigned C_STAT_BUSY = 0;
   localparam int unsigned C_STAT_DONE = 1;

   localparam logic [31:0] C_UNMAPPED_RD = 32'h0BAD_ADD0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } t_timer_state;
endpackage

// File: rtl/virtual_slave_regbank_timer.sv
// Countdown timer FSM (IDLE -> RUN -> FINISH -> IDLE) with the REMAIN counter.
// o_done_set pulses for the FINISH->IDLE edge unless that edge is aborted.
module virtual_slave_regbank_timer
   import virtual_slave_regbank_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_srst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [31:0] i_count,
   output logic        o_busy,
   output logic        o_done_set,
   output logic [31:0] o_remain
);
   t_timer_state r_state;
   logic         r_busy;
   logic [31:0]  r_remain;

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_remain <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // ABORT beats START when both arrive in the same CTRL write
               if (i_start && !i_abort) begin
                  r_remain <= i_count;
                  r_busy   <= 1'b1;
                  r_state  <= (i_count == 32'd0) ? ST_FINISH : ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_remain <= r_remain - 32'd1;
                  if (r_remain == 32'd1)
                     r_state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_remain   = r_remain;
   assign o_done_set = (r_state == ST_FINISH) && !i_abort;
endmodule

// File: rtl/virtual_slave_regbank.sv
// Word-addressed register bank: CTRL/COUNT/STATUS/REMAIN plus scratch words, registered reads.
// Optional countdown timer enabled by defining VIRTUAL_SLAVE_REGBANK_TIMER_EN.
module virtual_slave_regbank
   import virtual_slave_regbank_pkg::*;
#(
   parameter int C_ADDR_BITS = 10,
   parameter int C_REG_COUNT = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   WE,
   input  logic [C_ADDR_BITS-1:0] WADDR,
   input  logic [31:0]            WDATA,
   input  logic                   RE,
   input  logic [C_ADDR_BITS-1:0] RADDR,
   output logic [31:0]            RDATA,
   output logic                   IRQ,
   output logic                   BUSY
);
   localparam int C_SCR_N  = C_REG_COUNT - int'(C_IDX_SCR0);
   localparam int C_SIDX_W = (C_SCR_N > 1) ? $clog2(C_SCR_N) : 1;

   localparam logic [C_ADDR_BITS:0]   L_LIMIT  = (C_ADDR_BITS+1)'(C_REG_COUNT);
   localparam logic [C_ADDR_BITS-1:0] L_A_CTRL = C_ADDR_BITS'(C_IDX_CTRL);
   localparam logic [C_ADDR_BITS-1:0] L_A_CNT  = C_ADDR_BITS'(C_IDX_COUNT);
   localparam logic [C_ADDR_BITS-1:0] L_A_STAT = C_ADDR_BITS'(C_IDX_STATUS);
   localparam logic [C_ADDR_BITS-1:0] L_A_REM  = C_ADDR_BITS'(C_IDX_REMAIN);
   localparam logic [C_ADDR_BITS-1:0] L_A_SCR0 = C_ADDR_BITS'(C_IDX_SCR0);

   logic [31:0]         r_rdata;
   logic [31:0]         r_count;
   logic                r_irq_en;
   logic [31:0]         r_scratch [C_SCR_N];

   logic                w_wr_ok;
   logic                w_rd_ok;
   logic [C_SIDX_W-1:0] w_widx;
   logic [C_SIDX_W-1:0] w_ridx;
   logic                w_busy;
   logic                w_done;
   logic [31:0]         w_remain;
   logic [31:0]         w_rd_data;

   assign w_wr_ok = WE && ({1'b0, WADDR} < L_LIMIT);
   assign w_rd_ok = {1'b0, RADDR} < L_LIMIT;
   assign w_widx  = C_SIDX_W'(WADDR - L_A_SCR0);
   assign w_ridx  = C_SIDX_W'(RADDR - L_A_SCR0);

`ifdef VIRTUAL_SLAVE_REGBANK_TIMER_EN
   logic w_wr_ctrl;
   logic w_wr_status;
   logic w_done_set;
   logic r_done;

   assign w_wr_ctrl   = w_wr_ok && (WADDR == L_A_CTRL);
   assign w_wr_status = w_wr_ok && (WADDR == L_A_STAT);

   virtual_slave_regbank_timer u_timer (
      .i_clk      (CLK),
      .i_srst     (RST),
      .i_start    (w_wr_ctrl && WDATA[C_CTRL_START]),
      .i_abort    (w_wr_ctrl && WDATA[C_CTRL_ABORT]),
      .i_count    (r_count),
      .o_busy     (w_busy),
      .o_done_set (w_done_set),
      .o_remain   (w_remain)
   );

   // A completion landing on the same edge as a W1C keeps DONE set
   always_ff @(posedge CLK) begin
      if (RST)
         r_done <= 1'b0;
      else if (w_done_set)
         r_done <= 1'b1;
      else if (w_wr_status && WDATA[C_STAT_DONE])
         r_done <= 1'b0;
   end

   assign w_done = r_done;
   assign IRQ    = r_done && r_irq_en;
   assign BUSY   = w_busy;
`else
   assign w_busy   = 1'b0;
   assign w_done   = 1'b0;
   assign w_remain = '0;
   assign IRQ      = 1'b0;
   assign BUSY     = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count  <= '0;
         r_irq_en <= 1'b0;
         for (int i = 0; i < C_SCR_N; i++)
            r_scratch[i] <= '0;
      end else if (w_wr_ok) begin
         if (WADDR == L_A_CTRL)
            r_irq_en <= WDATA[C_CTRL_IRQ_EN];
         else if (WADDR == L_A_CNT)
            r_count <= WDATA;
         else if (WADDR >= L_A_SCR0)
            r_scratch[w_widx] <= WDATA;
      end
   end

   // Read mux sees pre-write state, so a same-edge write/read returns the old value
   always_comb begin
      w_rd_data = C_UNMAPPED_RD;
      if (w_rd_ok) begin
         w_rd_data = '0;
         if (RADDR == L_A_CTRL)
            w_rd_data[C_CTRL_IRQ_EN] = r_irq_en;
         else if (RADDR == L_A_CNT)
            w_rd_data = r_count;
         else if (RADDR == L_A_STAT) begin
            w_rd_data[C_STAT_BUSY] = w_busy;
            w_rd_data[C_STAT_DONE] = w_done;
         end else if (RADDR == L_A_REM)
            w_rd_data = w_remain;
         else
            w_rd_data = r_scratch[w_ridx];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)
         r_rdata <= '0;
      else if (RE)
         r_rdata <= w_rd_data;
   end

   assign RDATA = r_rdata;
endmodule

// File: tb/tb_virtual_slave_regbank.sv
// Self-checking bench for virtual_slave_regbank: vector table, timer sequences, random traffic vs model.
module tb_virtual_slave_regbank;
   localparam int AW   = 10;
   localparam int NREG = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          WE = 1'b0;
   logic [AW-1:0] WADDR = '0;
   logic [31:0]   WDATA = '0;
   logic          RE = 1'b0;
   logic [AW-1:0] RADDR = '0;
   logic [31:0]   RDATA;
   logic          IRQ;
   logic          BUSY;

   virtual_slave_regbank #(.C_ADDR_BITS(AW), .C_REG_COUNT(NREG)) dut (
      .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
      .RE(RE), .RADDR(RADDR), .RDATA(RDATA), .IRQ(IRQ), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: registers as plain values, timer as (start edge, length) arithmetic
   logic [31:0] m_scr [NREG];
   logic [31:0] m_count, m_rdata, m_frozen;
   bit          m_irq_en, m_done, m_active;
   longint      m_edge = 0, m_s = 0, m_n = 0;

   function automatic logic [31:0] m_remain();
      longint r;
      if (!m_active) return m_frozen;
      r = m_n - (m_edge - m_s);
      return (r < 0) ? 32'd0 : 32'(r);
   endfunction

   function automatic logic [31:0] m_read(input int a);
      if (a >= NREG) return 32'h0BAD_ADD0;
      case (a)
         0: return {30'd0, m_irq_en, 1'b0};
         1: return m_count;
         2: return {30'd0, m_done, m_active};
         3: return m_remain();
         default: return m_scr[a];
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) m_scr[i] = '0;
      m_count = '0; m_rdata = '0; m_frozen = '0;
      m_irq_en = 0; m_done = 0; m_active = 0;
   endtask

   task automatic step(input bit rst, input bit we, input int waddr, input logic [31:0] wdata,
                       input bit re, input int raddr);
      bit start, abort, done_set, done_clr;
      RST = rst; WE = we; WADDR = AW'(waddr); WDATA = wdata; RE = re; RADDR = AW'(raddr);
      @(posedge CLK);
      if (rst) begin
         m_reset();
         m_edge++;
      end else begin
         if (re) m_rdata = m_read(raddr);
         start = we && (waddr == 0) && wdata[0];
         abort = we && (waddr == 0) && wdata[2];
         done_set = 0;
         done_clr = we && (waddr == 2) && wdata[1];
         m_edge++;
`ifdef VIRTUAL_SLAVE_REGBANK_TIMER_EN
         if (m_active) begin
            if (abort) begin
               m_edge--; m_frozen = m_remain(); m_edge++;
               m_active = 0;
            end else if (m_edge - m_s == m_n + 1) begin
               m_active = 0; m_frozen = '0; done_set = 1;
            end
         end else if (start && !abort) begin
            m_active = 1; m_s = m_edge; m_n = longint'(m_count);
         end
`endif
         if (we && waddr < NREG) begin
            case (waddr)
               0: m_irq_en = wdata[1];
               1: m_count = wdata;
               2, 3: ;
               default: m_scr[waddr] = wdata;
            endcase
         end
         if (done_clr) m_done = 0;
         if (done_set) m_done = 1;
      end
      #1;
      $display("txn t=%0t rst=%0b we=%0b wa=%0d wd=%h re=%0b ra=%0d -> rd=%h irq=%0b busy=%0b",
               $time, rst, we, waddr, wdata, re, raddr, RDATA, IRQ, BUSY);
      RST = 0; WE = 0; RE = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string nm);
      chk({nm, "_rdata"}, RDATA, m_rdata);
      chk({nm, "_irq"}, 32'(IRQ), 32'(m_irq_en & m_done));
      chk({nm, "_busy"}, 32'(BUSY), 32'(m_active));
   endtask

   task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

   typedef struct {
      bit          rst;
      bit          we;
      int          waddr;
      logic [31:0] wdata;
      bit          re;
      int          raddr;
      logic [31:0] exp_rd;
      bit          exp_irq;
      bit          exp_busy;
   } vec_t;

   vec_t tbl [18];

   initial begin
      int nb;
      tbl = '{
         '{1, 0,  0, 32'h0,         0,  0, 32'h0,         0, 0},
         '{0, 1,  4, 32'hCAFE_F00D, 0,  0, 32'h0,         0, 0},
         '{0, 0,  0, 32'h0,         1,  4, 32'hCAFE_F00D, 0, 0},
         '{0, 0,  0, 32'h0,         1, 40, 32'h0BAD_ADD0, 0, 0},
         '{0, 1,  5, 32'h1,         1,  5, 32'h0,         0, 0},
         '{0, 0,  0, 32'h0,         1,  5, 32'h1,         0, 0},
         '{0, 1,  1, 32'h1234,      0,  0, 32'h1,         0, 0},
         '{0, 0,  0, 32'h0,         1,  1, 32'h1234,      0, 0},
         '{0, 1, 15, 32'hAA55,      1, 15, 32'h0,         0, 0},
         '{0, 0,  0, 32'h0,         1, 15, 32'hAA55,      0, 0},
         '{0, 1, 16, 32'hDEAD,      1, 16, 32'h0BAD_ADD0, 0, 0},
         '{0, 1,  0, 32'h2,         1,  0, 32'h0,         0, 0},
         '{0, 0,  0, 32'h0,         1,  0, 32'h2,         0, 0},
         '{0, 0,  0, 32'h0,         1,  2, 32'h0,         0, 0},
         '{0, 0,  0, 32'h0,         1,  3, 32'h0,         0, 0},
         '{0, 1,  3, 32'hFFFF,      1,  3, 32'h0,         0, 0},
         '{0, 0,  0, 32'h0,         1,  3, 32'h0,         0, 0},
         '{0, 1,  0, 32'h0,         1,  0, 32'h2,         0, 0}
      };

      m_reset();
      @(negedge CLK);
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].rst, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].re, tbl[i].raddr);
         chk($sformatf("tbl%0d_rdata", i), RDATA, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_irq", i), 32'(IRQ), 32'(tbl[i].exp_irq));
         chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].exp_busy));
      end

`ifdef VIRTUAL_SLAVE_REGBANK_TIMER_EN
      // COUNT=5 with START|IRQ_EN: six busy cycles, then DONE and IRQ
      step(0, 1, 1, 5, 0, 0);
      step(0, 1, 0, 3, 0, 0);
      nb = BUSY ? 1 : 0;
      for (int i = 0; i < 20 && BUSY; i++) begin idle(); if (BUSY) nb++; end
      chk("busy_len_n5", 32'(nb), 32'd6);
      chk("irq_after_done", 32'(IRQ), 32'd1);
      step(0, 0, 0, 0, 1, 2);
      chk("status_done", RDATA, 32'h2);
      step(0, 1, 2, 2, 0, 0);
      chk("irq_after_w1c", 32'(IRQ), 32'd0);

      // COUNT=0: one busy cycle then DONE; START+ABORT together stays idle
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      nb = BUSY ? 1 : 0;
      for (int i = 0; i < 20 && BUSY; i++) begin idle(); if (BUSY) nb++; end
      chk("busy_len_n0", 32'(nb), 32'd1);
      step(0, 0, 0, 0, 1, 2);
      chk("status_done_n0", RDATA, 32'h2);
      step(0, 1, 2, 2, 0, 0);
      step(0, 1, 0, 5, 0, 0);
      chk("start_abort_busy", 32'(BUSY), 32'd0);
      idle();
      chk("start_abort_busy2", 32'(BUSY), 32'd0);

      // COUNT=100, abort once REMAIN has reached 90
      step(0, 1, 1, 100, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) idle();
      step(0, 1, 0, 4, 0, 0);
      chk("abort_busy", 32'(BUSY), 32'd0);
      step(0, 0, 0, 0, 1, 3);
      chk("abort_remain", RDATA, 32'd90);
      step(0, 0, 0, 0, 1, 2);
      chk("abort_status", RDATA, 32'h0);

      // Reset in the middle of a run
      step(0, 1, 1, 50, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      idle(); idle();
      chk("run_busy", 32'(BUSY), 32'd1);
      step(1, 1, 5, 32'h77, 1, 3);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_rdata", RDATA, 32'h0);
      step(0, 0, 0, 0, 1, 3);
      chk("rst_remain", RDATA, 32'h0);
`else
      // Timer absent: START must not raise BUSY/IRQ and timer registers read 0
      step(0, 1, 1, 5, 0, 0);
      step(0, 1, 0, 3, 0, 0);
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (BUSY || IRQ) nb++;
         idle();
      end
      chk("notimer_busy_irq", 32'(nb), 32'd0);
      step(0, 0, 0, 0, 1, 2);
      chk("notimer_status", RDATA, 32'h0);
      step(0, 0, 0, 0, 1, 3);
      chk("notimer_remain", RDATA, 32'h0);
      step(0, 0, 0, 0, 1, 0);
      chk("notimer_ctrl", RDATA, 32'h2);
      step(0, 1, 2, 32'hFFFF_FFFF, 1, 2);
      step(0, 0, 0, 0, 1, 2);
      chk("notimer_status_w", RDATA, 32'h0);
`endif

      // Randomized traffic checked against the model every cycle
      for (int i = 0; i < 400; i++) begin
         int wa, ra;
         logic [31:0] wd;
         wa = ($urandom_range(0, 15) == 0) ? 1023 : int'($urandom_range(0, NREG + 3));
         ra = ($urandom_range(0, 15) == 0) ? 700 : int'($urandom_range(0, NREG + 3));
         wd = $urandom;
         if (wa == 1) wd = $urandom_range(0, 6);
         if (wa == 0) wd = {29'd0, wd[2:0]} & (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h3);
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0), wa, wd,
              ($urandom_range(0, 1) == 0), ra);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/virtual_slave_regbank.md
VIRTUAL_SLAVE_REGBANK -- requirements
Module: virtual_slave_regbank

Interface
REQ-001 The block SHALL have parameter C_ADDR_BITS, default 10: width of WADDR/RADDR in word addresses.
REQ-002 The block SHALL have parameter C_REG_COUNT, default 16: number of implemented 32-bit word registers, legal range 5..2^C_ADDR_BITS.
REQ-003 The block SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port WE  input  1  write strobe, one word per cycle.
REQ-006 The block SHALL have port WADDR  input  C_ADDR_BITS  write word address.
REQ-007 The block SHALL have port WDATA  input  32  write data.
REQ-008 The block SHALL have port RE  input  1  read strobe.
REQ-009 The block SHALL have port RADDR  input  C_ADDR_BITS  read word address.
REQ-010 The block SHALL have port RDATA  output  32  registered read data.
REQ-011 The block SHALL have port IRQ  output  1  level interrupt, DONE & IRQ_EN.
REQ-012 The block SHALL have port BUSY  output  1  high while the timer FSM is in RUN or FINISH.

Function
REQ-013 The register map SHALL be: 0 CTRL, 1 COUNT (RW), 2 STATUS, 3 REMAIN (RO), 4..C_REG_COUNT-1 scratch (RW).
REQ-014 CTRL fields SHALL be: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (RW), bit2 ABORT (write-1 pulse, reads 0).
REQ-015 STATUS fields SHALL be: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear); other bits read 0.
REQ-016 Writes to RO fields or to addresses >= C_REG_COUNT SHALL be ignored.
REQ-017 Reads from addresses >= C_REG_COUNT SHALL return 32'h0BAD_ADD0.
REQ-018 A read sampled with RE=1 at edge k SHALL drive RDATA after edge k; RDATA SHALL hold until the next accepted read.
REQ-019 A read and a write to the same address at the same edge SHALL return the pre-write value.
REQ-020 The timer FSM SHALL have states IDLE, RUN and FINISH.
REQ-021 In IDLE, a START write at edge k with COUNT=N>0 SHALL enter RUN at edge k with REMAIN=N.
REQ-022 A START write at edge k with COUNT=0 SHALL enter FINISH at edge k.
REQ-023 In RUN, REMAIN SHALL decrement by 1 per edge; the state SHALL move to FINISH at the edge where REMAIN becomes 0.
REQ-024 FINISH SHALL go to IDLE after one cycle, setting DONE.
REQ-025 BUSY SHALL therefore be high for N+1 cycles.
REQ-026 START in RUN or FINISH SHALL be ignored.
REQ-027 ABORT in RUN or FINISH SHALL go to IDLE without setting DONE; REMAIN SHALL keep its value.
REQ-028 When START and ABORT are written together, ABORT SHALL win.
REQ-029 If a DONE set and a DONE W1C occur at the same edge, the set SHALL win.
REQ-030 Writing COUNT during RUN SHALL NOT affect REMAIN.
REQ-031 IRQ SHALL be derived only from flops, with no combinational path from any input.

Reset
REQ-032 On RST sampled high, the block SHALL clear RDATA, COUNT, IRQ_EN, DONE, REMAIN and all scratch registers to 0.
REQ-033 On RST sampled high, the FSM SHALL go to IDLE, and IRQ and BUSY SHALL be 0 after that edge.
REQ-034 RST SHALL override any simultaneous WE or RE, including a reset that arrives mid-RUN.

Configuration
REQ-035 Macro VIRTUAL_SLAVE_REGBANK_TIMER_EN defined: the timer FSM, REMAIN, DONE, IRQ and BUSY SHALL behave as specified above.
REQ-036 Macro VIRTUAL_SLAVE_REGBANK_TIMER_EN undefined: CTRL bits 0/2, STATUS and REMAIN SHALL read 0 and ignore writes; IRQ and BUSY SHALL be tied 0; the remaining registers and read timing SHALL be unchanged.

Structure
REQ-037 Package virtual_slave_regbank_pkg SHALL hold:
- register index constants;
- CTRL/STATUS bit positions;
- the FSM state enum;
- the unmapped-read constant 32'h0BAD_ADD0.
REQ-038 The FSM and REMAIN counter SHALL live in sub-module virtual_slave_regbank_timer, instantiated only under VIRTUAL_SLAVE_REGBANK_TIMER_EN.

Verification
REQ-039 Scenario: write scratch 4 = 32'hCAFE_F00D, then read 4 -> RDATA=32'hCAFE_F00D one edge later; read address 40 -> 32'h0BAD_ADD0.
REQ-040 Scenario: COUNT=5, CTRL=3 (START|IRQ_EN) -> BUSY high exactly 6 cycles, then DONE=1 and IRQ=1; STATUS write 2 -> IRQ=0 next edge.
REQ-041 Scenario: COUNT=0, START -> BUSY 1 cycle, DONE set; START+ABORT written together (CTRL=5) -> FSM stays IDLE.
REQ-042 Scenario: COUNT=100, START, ABORT after 10 cycles -> REMAIN=90 (±0 by exact edge count), DONE=0.
REQ-043 Scenario: same-edge write 32'h1 / read of scratch 5 holding 32'h0 -> RDATA=0; RST mid-RUN -> BUSY=0 and REMAIN=0 next edge.
REQ-044 Scenario: regression with the macro undefined -> IRQ and BUSY stay 0; REQ-039 still passes.
